// File: rtl/doc_wave_ram_ctrl_if.sv
// doc_wave_ram_ctrl_if
//   Requester-side bundle of the wave-memory controller: the DOC5503
//   wavetable fetch port and the Sound GLU host access port.
//   master : requester side (DOC engine / host glue)
//   slave  : controller side (doc_wave_ram_ctrl)
//   DOC   : wave_address_i, wave_rd_i -> wave_data_ready_o, wave_data_o
//   Host  : host_req_i, host_we_i, host_addr_i, host_wdata_i -> host_ack_o, host_rdata_o
interface doc_wave_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] wave_address_i;
  logic                  wave_rd_i;
  logic                  wave_data_ready_o;
  logic [7:0]            wave_data_o;
  logic                  host_req_i;
  logic                  host_we_i;
  logic [ADDR_WIDTH-1:0] host_addr_i;
  logic [7:0]            host_wdata_i;
  logic                  host_ack_o;
  logic [7:0]            host_rdata_o;

  modport master (
    output wave_address_i, wave_rd_i, host_req_i, host_we_i, host_addr_i, host_wdata_i,
    input  wave_data_ready_o, wave_data_o, host_ack_o, host_rdata_o
  );

  modport slave (
    input  wave_address_i, wave_rd_i, host_req_i, host_we_i, host_addr_i, host_wdata_i,
    output wave_data_ready_o, wave_data_o, host_ack_o, host_rdata_o
  );
endinterface

// File: rtl/doc_wave_ram_ctrl.sv
// doc_wave_ram_ctrl
//   Wave-memory controller in front of the DOC5503. Arbitrates DOC wavetable
//   fetches against host (Sound GLU) loads onto a single-port synchronous
//   sound RAM with RAM_LATENCY (1..4) cycles of read latency. One access in
//   flight at a time: IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE.
//   Ports:
//     clk_i, reset_i      clock, asynchronous active-high reset
//     bus (slave)         DOC fetch port + host access port
//     ram_en_o/ram_we_o   one-cycle RAM strobe / write enable
//     ram_addr_o          RAM address, ram_wdata_o write data
//     ram_rdata_i         RAM read data, valid RAM_LATENCY cycles after ram_en_o
//   Build option:
//     DOC_FETCH_CACHE_EN  one-entry DOC fetch cache (address/data/valid),
//                         hits answered from IDLE without touching the RAM,
//                         host writes to the cached address are written through.
module doc_wave_ram_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  doc_wave_ram_ctrl_if.slave    bus,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]            ram_wdata_o,
  input  logic [7:0]            ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // WAIT lasts RAM_LATENCY cycles; the counter reaches 0 in the cycle the
  // RAM data is valid.
  localparam logic [1:0] LAT_LOAD = 2'(RAM_LATENCY - 1);

  state_t     state;
  logic [1:0] lat_cnt;
  logic       fair;       // host gets priority on the next contended IDLE
  logic       doc_armed;  // one fetch per wave_rd_i high period
  logic       owner_doc;
  logic       is_write;

  logic doc_elig, grant_host, grant_doc, doc_complete;

`ifdef DOC_FETCH_CACHE_EN
  logic                  c_valid;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [7:0]            c_data;
  logic                  cache_hit;
`endif

  always_comb begin
    doc_elig     = bus.wave_rd_i && doc_armed;
    grant_host   = (state == IDLE) && bus.host_req_i && (!doc_elig || fair);
    grant_doc    = (state == IDLE) && doc_elig && !grant_host;
    doc_complete = (state == WAIT) && (lat_cnt == 2'd0) && owner_doc;
`ifdef DOC_FETCH_CACHE_EN
    cache_hit    = grant_doc && c_valid && (c_addr == bus.wave_address_i);
    doc_complete = doc_complete || cache_hit;
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state                 <= IDLE;
      lat_cnt               <= 2'd0;
      fair                  <= 1'b0;
      doc_armed             <= 1'b1;
      owner_doc             <= 1'b0;
      is_write              <= 1'b0;
      ram_en_o              <= 1'b0;
      ram_we_o              <= 1'b0;
      ram_addr_o            <= '0;
      ram_wdata_o           <= '0;
      bus.wave_data_ready_o <= 1'b0;
      bus.wave_data_o       <= '0;
      bus.host_ack_o        <= 1'b0;
      bus.host_rdata_o      <= '0;
`ifdef DOC_FETCH_CACHE_EN
      c_valid               <= 1'b0;
      c_addr                <= '0;
      c_data                <= '0;
`endif
    end else begin
      // strobes and pulses are single-cycle unless re-asserted below
      ram_en_o              <= 1'b0;
      ram_we_o              <= 1'b0;
      bus.wave_data_ready_o <= 1'b0;
      bus.host_ack_o        <= 1'b0;

      // a low wave_rd_i always re-arms, even if the DOC withdrew mid-fetch
      if (!bus.wave_rd_i)    doc_armed <= 1'b1;
      else if (doc_complete) doc_armed <= 1'b0;

      case (state)
        IDLE: begin
`ifdef DOC_FETCH_CACHE_EN
          if (cache_hit) begin
            bus.wave_data_o       <= c_data;
            bus.wave_data_ready_o <= 1'b1;
          end else
`endif
          if (grant_doc || grant_host) begin
            ram_en_o   <= 1'b1;
            ram_we_o   <= grant_host && bus.host_we_i;
            ram_addr_o <= grant_host ? bus.host_addr_i : bus.wave_address_i;
            if (grant_host) ram_wdata_o <= bus.host_wdata_i;
            owner_doc  <= grant_doc;
            is_write   <= grant_host && bus.host_we_i;
            state      <= ISSUE;
            if (grant_host)           fair <= 1'b0;
            else if (bus.host_req_i)  fair <= 1'b1;
          end
        end
        ISSUE: begin
          if (is_write) begin
            bus.host_ack_o <= 1'b1;
            state          <= DONE;
`ifdef DOC_FETCH_CACHE_EN
            if (c_valid && (c_addr == ram_addr_o)) c_data <= ram_wdata_o;
`endif
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            if (owner_doc) begin
              bus.wave_data_o       <= ram_rdata_i;
              bus.wave_data_ready_o <= 1'b1;
`ifdef DOC_FETCH_CACHE_EN
              c_valid               <= 1'b1;
              c_addr                <= ram_addr_o;
              c_data                <= ram_rdata_i;
`endif
            end else begin
              bus.host_rdata_o <= ram_rdata_i;
              bus.host_ack_o   <= 1'b1;
            end
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
